// File: rtl/glitcher_pkg.sv
// Shared definitions for the glitcher trigger path: FSM state encoding,
// edge-select encodings and the edge-select match helper.
package glitcher_pkg;

  // Trigger FSM states; the remaining two 3-bit codes are unused and recover to IDLE
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARMED      = 3'd1,
    QUALIFY    = 3'd2,
    FIRE       = 3'd3,
    WAIT_START = 3'd4,
    WAIT_DONE  = 3'd5
  } state_t;

  // Trigger source selection
  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_ANY  = 2'b10;
  localparam logic [1:0] EDGE_SW   = 2'b11;

  // True when the detected edges match the selected source (software mode never matches)
  function automatic logic edge_match(input logic [1:0] sel, input logic rise, input logic fall);
    logic hit;
    hit = 1'b0;
    case (sel)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_ANY:  hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input followed by a history
// flop, producing the synchronized level and single-cycle rise/fall strobes.
// The chain updates every cycle regardless of the consumer's state, so a
// level that was already present never looks like a fresh edge.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;

  // Shift the asynchronous input through the synchronizer and remember the previous level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
      hist_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
      hist_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = level & ~hist_reg;
  assign fall  = ~level & hist_reg;

endmodule

// File: rtl/trigger_unit.sv
// Trigger conditioning for the pulse generator: edge select, stability
// filter, arm/disarm, one-shot versus re-arm, and holdoff while the pulser
// is busy. Issues a single-cycle en_o per accepted trigger.
// Optional feature macro: TRIG_COUNT_EN adds a 16-bit wrapping count of
// en_o pulses on trig_count_o.
module trigger_unit
  import glitcher_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig_i,
  input  logic       arm_i,
  input  logic       disarm_i,
  input  logic       sw_trig_i,
  input  logic [1:0] edge_sel_i,
  input  logic [7:0] filter_len_i,
  input  logic       oneshot_i,
  input  logic       pulser_busy_i,
  output logic       en_o,
  output logic       armed_o
`ifdef TRIG_COUNT_EN
  ,
  output logic [15:0] trig_count_o
`endif
);

  state_t     state_reg, state_next;
  logic [1:0] edge_sel_reg;
  logic [7:0] filter_len_reg;
  logic       oneshot_reg;
  logic [7:0] cnt_reg, cnt_next, cnt_inc;
  logic       latched_reg, latched_next;
  logic       disarm_pend_reg, disarm_pend_next;
  logic       level, rise, fall;
  logic       edge_hit;
  logic       arm_accept;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (trig_i),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  assign arm_accept = (state_reg == IDLE) && arm_i && !disarm_i;
  assign edge_hit   = edge_match(edge_sel_reg, rise, fall);
  assign cnt_inc    = cnt_reg + 8'd1;

  // Capture the trigger configuration only when IDLE accepts an arm request
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_sel_reg   <= 2'b00;
      filter_len_reg <= 8'd0;
      oneshot_reg    <= 1'b0;
    end else if (arm_accept) begin
      edge_sel_reg   <= edge_sel_i;
      filter_len_reg <= filter_len_i;
      oneshot_reg    <= oneshot_i;
    end
  end

  // State, filter counter, latched level and deferred disarm registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= 8'd0;
      latched_reg     <= 1'b0;
      disarm_pend_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      latched_reg     <= latched_next;
      disarm_pend_reg <= disarm_pend_next;
    end
  end

  // Next-state logic; a disarm seen in FIRE is held over and applied one cycle later
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    latched_next     = latched_reg;
    disarm_pend_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (arm_i && !disarm_i) state_next = ARMED;
      end
      ARMED: begin
        if (disarm_i) begin
          state_next = IDLE;
        end else if (sw_trig_i) begin
          state_next = FIRE;
        end else if (edge_hit) begin
          if (filter_len_reg == 8'd0) begin
            state_next = FIRE;
          end else begin
            state_next   = QUALIFY;
            cnt_next     = 8'd0;
            latched_next = level;
          end
        end
      end
      QUALIFY: begin
        if (disarm_i) begin
          state_next = IDLE;
        end else if (sw_trig_i) begin
          state_next = FIRE;
        end else if (level != latched_reg) begin
          state_next = ARMED;
        end else if (cnt_inc == filter_len_reg) begin
          state_next = FIRE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      FIRE: begin
        state_next       = WAIT_START;
        disarm_pend_next = disarm_i;
      end
      WAIT_START: begin
        if (disarm_i || disarm_pend_reg) begin
          state_next = IDLE;
        end else if (pulser_busy_i) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (disarm_i) begin
          state_next = IDLE;
        end else if (!pulser_busy_i) begin
          state_next = oneshot_reg ? IDLE : ARMED;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign en_o    = (state_reg == FIRE);
  assign armed_o = (state_reg == ARMED) || (state_reg == QUALIFY);

`ifdef TRIG_COUNT_EN
  logic [15:0] trig_count_reg;

  // Count issued start pulses, wrapping naturally at 16 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_count_reg <= 16'd0;
    end else if (state_reg == FIRE) begin
      trig_count_reg <= trig_count_reg + 16'd1;
    end
  end

  assign trig_count_o = trig_count_reg;
`endif

endmodule

// File: tb/tb_trigger_unit.sv
// Self-checking bench for trigger_unit: a table of single-trigger scenarios
// plus hand-written sequences for re-arm, held level, disarm, reset,
// software trigger and (with TRIG_COUNT_EN) the trigger counter.
module tb_trigger_unit;
  import glitcher_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       trig_i;
  logic       arm_i;
  logic       disarm_i;
  logic       sw_trig_i;
  logic [1:0] edge_sel_i;
  logic [7:0] filter_len_i;
  logic       oneshot_i;
  logic       pulser_busy_i;
  logic       en_o;
  logic       armed_o;
`ifdef TRIG_COUNT_EN
  logic [15:0] trig_count_o;
`endif

  trigger_unit #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .trig_i       (trig_i),
    .arm_i        (arm_i),
    .disarm_i     (disarm_i),
    .sw_trig_i    (sw_trig_i),
    .edge_sel_i   (edge_sel_i),
    .filter_len_i (filter_len_i),
    .oneshot_i    (oneshot_i),
    .pulser_busy_i(pulser_busy_i),
    .en_o         (en_o),
    .armed_o      (armed_o)
`ifdef TRIG_COUNT_EN
    ,
    .trig_count_o (trig_count_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int en_total = 0;
  int busy_len = 10;
  int busy_left = 0;
  bit busy_pend = 1'b0;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] filt;
    logic       oneshot;
    logic       init;
    int         hold;
    int         exp_fires;
    int         exp_lat;
    logic       exp_armed;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // One clock: sample outputs 1 ns after the edge and run the pulser model
  task automatic tick();
    @(posedge clk);
    #1;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) pulser_busy_i = 1'b0;
    end
    if (busy_pend) begin
      pulser_busy_i = 1'b1;
      busy_left = busy_len;
      busy_pend = 1'b0;
    end
    if (en_o === 1'b1) begin
      en_total++;
      busy_pend = 1'b1;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    trig_i = 1'b0; arm_i = 1'b0; disarm_i = 1'b0; sw_trig_i = 1'b0;
    edge_sel_i = 2'b00; filter_len_i = 8'd0; oneshot_i = 1'b0;
    pulser_busy_i = 1'b0; busy_left = 0; busy_pend = 1'b0; busy_len = 10;
    ticks(2);
    rst = 1'b0;
    tick();
    en_total = 0;
  endtask

  task automatic arm(input logic [1:0] sel, input logic [7:0] filt, input logic os);
    edge_sel_i = sel; filter_len_i = filt; oneshot_i = os; arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    // scramble the live config to show only the captured copy matters
    edge_sel_i = ~sel; filter_len_i = ~filt; oneshot_i = ~os;
  endtask

  initial begin
    int first_t;
    int prev;
    vecs[0]  = '{2'b00, 8'd0, 1'b1, 1'b0, 20, 1, 3, 1'b0};
    vecs[1]  = '{2'b01, 8'd0, 1'b0, 1'b1, 20, 1, 3, 1'b1};
    vecs[2]  = '{2'b10, 8'd0, 1'b1, 1'b0, 20, 1, 3, 1'b0};
    vecs[3]  = '{2'b10, 8'd2, 1'b1, 1'b1, 20, 1, 5, 1'b0};
    vecs[4]  = '{2'b00, 8'd5, 1'b0, 1'b0, 20, 1, 8, 1'b1};
    vecs[5]  = '{2'b00, 8'd5, 1'b0, 1'b0, 6,  1, 8, 1'b1};
    vecs[6]  = '{2'b00, 8'd5, 1'b0, 1'b0, 5,  0, 0, 1'b1};
    vecs[7]  = '{2'b00, 8'd5, 1'b0, 1'b0, 3,  0, 0, 1'b1};
    vecs[8]  = '{2'b01, 8'd0, 1'b0, 1'b0, 99, 0, 0, 1'b1};
    vecs[9]  = '{2'b11, 8'd0, 1'b0, 1'b0, 99, 0, 0, 1'b1};
    vecs[10] = '{2'b00, 8'd1, 1'b0, 1'b0, 2,  1, 4, 1'b1};
    vecs[11] = '{2'b00, 8'd1, 1'b0, 1'b0, 1,  0, 0, 1'b1};

    // ---------------- table-driven single-trigger scenarios ----------------
    for (int v = 0; v < 12; v++) begin
      do_reset();
      chk($sformatf("v%0d_reset_en", v), int'(en_o), 0);
      chk($sformatf("v%0d_reset_armed", v), int'(armed_o), 0);
      trig_i = vecs[v].init;
      ticks(4);
      arm(vecs[v].sel, vecs[v].filt, vecs[v].oneshot);
      chk($sformatf("v%0d_armed", v), int'(armed_o), 1);
      tick();
      trig_i = ~vecs[v].init;
      first_t = 0;
      for (int t = 1; t <= 40; t++) begin
        prev = en_total;
        tick();
        if (en_total != prev && first_t == 0) first_t = t;
        if (t == vecs[v].hold) trig_i = vecs[v].init;
      end
      chk($sformatf("v%0d_fires", v), en_total, vecs[v].exp_fires);
      if (vecs[v].exp_fires > 0) chk($sformatf("v%0d_latency", v), first_t, vecs[v].exp_lat);
      chk($sformatf("v%0d_armed_end", v), int'(armed_o), int'(vecs[v].exp_armed));
      $display("vec %0d: sel=%0d filt=%0d hold=%0d fires=%0d latency=%0d armed=%0b",
               v, vecs[v].sel, vecs[v].filt, vecs[v].hold, en_total, first_t, armed_o);
    end

    // ---------------- re-arm: edges during busy are dropped ----------------
    do_reset();
    arm(EDGE_RISE, 8'd0, 1'b0);
    tick();
    trig_i = 1'b1;
    ticks(3);
    chk("rearm_first_en", int'(en_o), 1);
    ticks(2); trig_i = 1'b0;
    ticks(2); trig_i = 1'b1;
    ticks(20);
    chk("rearm_busy_edge_dropped", en_total, 1);
    chk("rearm_armed", int'(armed_o), 1);
    trig_i = 1'b0; ticks(3);
    trig_i = 1'b1; ticks(6);
    chk("rearm_second_fire", en_total, 2);
    $display("seq rearm: fires=%0d armed=%0b", en_total, armed_o);

    // ---------------- level held across arming ----------------
    do_reset();
    trig_i = 1'b1; ticks(4);
    arm(EDGE_RISE, 8'd0, 1'b1);
    ticks(10);
    chk("held_no_fire", en_total, 0);
    chk("held_still_armed", int'(armed_o), 1);
    trig_i = 1'b0; ticks(4);
    trig_i = 1'b1; ticks(6);
    chk("held_fire_after_new_edge", en_total, 1);
    ticks(20);
    chk("oneshot_idle", int'(armed_o), 0);
    $display("seq held: fires=%0d armed=%0b", en_total, armed_o);

    // ---------------- disarm during QUALIFY ----------------
    do_reset();
    arm(EDGE_RISE, 8'd10, 1'b0);
    tick();
    trig_i = 1'b1;
    ticks(5);
    chk("qual_armed", int'(armed_o), 1);
    disarm_i = 1'b1; tick(); disarm_i = 1'b0;
    chk("qual_disarm_idle", int'(armed_o), 0);
    ticks(20);
    chk("qual_disarm_no_fire", en_total, 0);
    $display("seq disarm: fires=%0d armed=%0b", en_total, armed_o);

    // ---------------- reset during WAIT_DONE ----------------
    do_reset();
    busy_len = 30;
    arm(EDGE_RISE, 8'd0, 1'b0);
    tick();
    trig_i = 1'b1;
    ticks(8);
    chk("wd_fired", en_total, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("wd_rst_en", int'(en_o), 0);
    chk("wd_rst_armed", int'(armed_o), 0);
`ifdef TRIG_COUNT_EN
    chk("wd_rst_count", int'(trig_count_o), 0);
`endif
    busy_left = 0; pulser_busy_i = 1'b0;
    ticks(5);
    chk("wd_rst_stays_idle", int'(armed_o), 0);
    $display("seq reset: armed=%0b en=%0b", armed_o, en_o);

    // ---------------- arm and disarm together ----------------
    do_reset();
    arm_i = 1'b1; disarm_i = 1'b1; tick();
    arm_i = 1'b0; disarm_i = 1'b0; tick();
    chk("arm_disarm_idle", int'(armed_o), 0);
    arm(EDGE_RISE, 8'd0, 1'b0);
    chk("arm_latency", int'(armed_o), 1);
    disarm_i = 1'b1; tick(); disarm_i = 1'b0;
    chk("armed_disarm", int'(armed_o), 0);
    $display("seq arm/disarm: armed=%0b", armed_o);

    // ---------------- software trigger ----------------
    do_reset();
    arm(EDGE_SW, 8'd0, 1'b1);
    ticks(2);
    sw_trig_i = 1'b1; tick(); sw_trig_i = 1'b0;
    chk("sw_en", int'(en_o), 1);
    tick();
    chk("sw_en_single", int'(en_o), 0);
    $display("seq sw: fires=%0d", en_total);

    // sw trigger and a matching edge in the same cycle give one fire
    do_reset();
    arm(EDGE_RISE, 8'd0, 1'b1);
    tick();
    trig_i = 1'b1;
    ticks(2);
    sw_trig_i = 1'b1; tick(); sw_trig_i = 1'b0;
    chk("sw_edge_en", int'(en_o), 1);
    ticks(10);
    chk("sw_edge_single", en_total, 1);
    $display("seq sw+edge: fires=%0d", en_total);

    // disarm during FIRE: pulse stands, unit ends up idle instead of re-arming
    do_reset();
    arm(EDGE_SW, 8'd0, 1'b0);
    tick();
    sw_trig_i = 1'b1; tick(); sw_trig_i = 1'b0;
    chk("fire_disarm_en", int'(en_o), 1);
    disarm_i = 1'b1; tick(); disarm_i = 1'b0;
    ticks(25);
    chk("fire_disarm_idle", int'(armed_o), 0);
    chk("fire_disarm_one_pulse", en_total, 1);
    $display("seq fire disarm: fires=%0d armed=%0b", en_total, armed_o);

`ifdef TRIG_COUNT_EN
    // ---------------- trigger counter ----------------
    do_reset();
    busy_len = 2;
    arm(EDGE_SW, 8'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      sw_trig_i = 1'b1; tick(); sw_trig_i = 1'b0;
      ticks(8);
    end
    chk("count_three", int'(trig_count_o), 3);
    @(negedge clk);
    dut.trig_count_reg = 16'hFFFF;
    tick();
    sw_trig_i = 1'b1; tick(); sw_trig_i = 1'b0;
    ticks(2);
    chk("count_wrap", int'(trig_count_o), 0);
    $display("seq counter: count=%0d", trig_count_o);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
